// File: rtl/operand_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : operand_fetch_unit                                           |
// | Description : Decode-to-execute operand fetch stage. Reads source operands |
// |               from a combinational register file, tracks outstanding       |
// |               destination writes in a busy scoreboard, stalls decode on    |
// |               read-after-write hazards, and forwards writeback traffic to  |
// |               the register-file write port.                                |
// | Options     : define OPERAND_FORWARDING_EN to bypass same-cycle writeback  |
// |               data into the operands instead of stalling for it.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module operand_fetch_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  // decode-side handshake
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [DEPTH-1:0] dec_rs1,
  input  logic [DEPTH-1:0] dec_rs2,
  input  logic [DEPTH-1:0] dec_rd,
  input  logic             dec_rd_write,
  // register-file read ports
  output logic             rf_read_enable_1,
  output logic             rf_read_enable_2,
  output logic [DEPTH-1:0] rf_read_index_1,
  output logic [DEPTH-1:0] rf_read_index_2,
  input  logic [WIDTH-1:0] rf_read_data_1,
  input  logic [WIDTH-1:0] rf_read_data_2,
  // register-file write port
  output logic             rf_write_enable,
  output logic [DEPTH-1:0] rf_write_index,
  output logic [WIDTH-1:0] rf_write_data,
  // writeback from execute
  input  logic             wb_valid,
  input  logic [DEPTH-1:0] wb_index,
  input  logic [WIDTH-1:0] wb_data,
  // execute-side handshake
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_rs1_data,
  output logic [WIDTH-1:0] ex_rs2_data,
  output logic [DEPTH-1:0] ex_rd,
  output logic             ex_rd_write,
  // statistics
  output logic [15:0]      stall_count
);

  localparam int          c_num_regs  = 1 << DEPTH;
  localparam logic [15:0] c_stall_max = 16'hFFFF;

  // scoreboard and pipeline registers
  logic [c_num_regs-1:0] r_busy;
  logic [c_num_regs-1:0] w_busy_nxt;
  logic                  r_ex_valid;
  logic [WIDTH-1:0]      r_ex_rs1_data;
  logic [WIDTH-1:0]      r_ex_rs2_data;
  logic [DEPTH-1:0]      r_ex_rd;
  logic                  r_ex_rd_write;
  logic [15:0]           r_stall_count;

  // hazard / handshake wires
  logic             w_fwd1;
  logic             w_fwd2;
  logic             w_hazard1;
  logic             w_hazard2;
  logic             w_hazard;
  logic             w_ex_free;
  logic             w_dec_ready;
  logic             w_issue;
  logic             w_set_en;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;

  // Read ports mirror the decode request directly; the register file answers
  // in the same cycle.
  assign rf_read_enable_1 = dec_valid;
  assign rf_read_enable_2 = dec_valid;
  assign rf_read_index_1  = dec_rs1;
  assign rf_read_index_2  = dec_rs2;

  // Writeback passes straight through; r0 is hard-wired and never written.
  assign rf_write_enable = wb_valid && (wb_index != '0);
  assign rf_write_index  = wb_index;
  assign rf_write_data   = wb_data;

`ifdef OPERAND_FORWARDING_EN
  // A writeback landing on a source this cycle supplies that operand directly.
  assign w_fwd1 = wb_valid && (wb_index == dec_rs1) && (dec_rs1 != '0);
  assign w_fwd2 = wb_valid && (wb_index == dec_rs2) && (dec_rs2 != '0);
`else
  // No bypass: a source still busy this cycle waits until the register file
  // has committed the writeback.
  assign w_fwd1 = 1'b0;
  assign w_fwd2 = 1'b0;
`endif

  // A source blocks only if it is a real register with an outstanding write
  // that is not being bypassed.
  assign w_hazard1 = (dec_rs1 != '0) && r_busy[dec_rs1] && !w_fwd1;
  assign w_hazard2 = (dec_rs2 != '0) && r_busy[dec_rs2] && !w_fwd2;
  assign w_hazard  = w_hazard1 || w_hazard2;

  // The output register can accept a new instruction when empty or draining.
  assign w_ex_free   = !r_ex_valid || ex_ready;
  assign w_dec_ready = w_ex_free && !w_hazard;
  assign dec_ready   = w_dec_ready;
  assign w_issue     = dec_valid && w_dec_ready;

  // Operand selection: r0 reads as zero, bypass beats register-file data.
  assign w_op1 = (dec_rs1 == '0) ? '0 : (w_fwd1 ? wb_data : rf_read_data_1);
  assign w_op2 = (dec_rs2 == '0) ? '0 : (w_fwd2 ? wb_data : rf_read_data_2);

  // Destination becomes busy when a writing instruction leaves for execute.
  assign w_set_en = w_issue && dec_rd_write && (dec_rd != '0);

  // Per-register next busy state: a set in the same cycle as a clear wins,
  // and entry 0 is permanently idle.
  for (genvar gi = 0; gi < c_num_regs; gi++) begin : g_busy_nxt
    if (gi == 0) begin : g_zero
      assign w_busy_nxt[gi] = 1'b0;
    end else begin : g_live
      assign w_busy_nxt[gi] = (w_set_en && (dec_rd == DEPTH'(gi))) ||
                              (r_busy[gi] && !(wb_valid && (wb_index == DEPTH'(gi))));
    end
  end

  // Scoreboard register, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Execute-side output register: load on issue, drop after a consumed
  // transfer, otherwise hold steady under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_valid    <= 1'b0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_rd       <= '0;
      r_ex_rd_write <= 1'b0;
    end else if (w_issue) begin
      r_ex_valid    <= 1'b1;
      r_ex_rs1_data <= w_op1;
      r_ex_rs2_data <= w_op2;
      r_ex_rd       <= dec_rd;
      r_ex_rd_write <= dec_rd_write;
    end else if (r_ex_valid && ex_ready) begin
      r_ex_valid    <= 1'b0;
    end
  end

  // Count only cycles lost to data hazards, saturating at the top.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (dec_valid && w_hazard && (r_stall_count != c_stall_max)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_rs1_data = r_ex_rs1_data;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_rd       = r_ex_rd;
  assign ex_rd_write = r_ex_rd_write;
  assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_operand_fetch_unit                                        |
// | Description : Scoreboard bench for operand_fetch_unit. Acts as the         |
// |               register file, drives directed and random traffic, predicts  |
// |               operand bundles from an architectural model and checks them  |
// |               as execute consumes them. Honours OPERAND_FORWARDING_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_operand_fetch_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int NREGS = 1 << DEPTH;

  logic             clk = 1'b0;
  logic             reset;
  logic             dec_valid, dec_ready, dec_rd_write;
  logic [DEPTH-1:0] dec_rs1, dec_rs2, dec_rd;
  logic             rf_read_enable_1, rf_read_enable_2;
  logic [DEPTH-1:0] rf_read_index_1, rf_read_index_2;
  logic [WIDTH-1:0] rf_read_data_1, rf_read_data_2;
  logic             rf_write_enable;
  logic [DEPTH-1:0] rf_write_index;
  logic [WIDTH-1:0] rf_write_data;
  logic             wb_valid;
  logic [DEPTH-1:0] wb_index;
  logic [WIDTH-1:0] wb_data;
  logic             ex_valid, ex_ready, ex_rd_write;
  logic [WIDTH-1:0] ex_rs1_data, ex_rs2_data;
  logic [DEPTH-1:0] ex_rd;
  logic [15:0]      stall_count;

  operand_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_write(dec_rd_write),
    .rf_read_enable_1(rf_read_enable_1), .rf_read_enable_2(rf_read_enable_2),
    .rf_read_index_1(rf_read_index_1), .rf_read_index_2(rf_read_index_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .rf_write_enable(rf_write_enable), .rf_write_index(rf_write_index),
    .rf_write_data(rf_write_data),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rd_write(ex_rd_write),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Register file environment: combinational read, write on the clock edge.
  logic [WIDTH-1:0] rf_mem [NREGS];
  assign rf_read_data_1 = rf_mem[rf_read_index_1];
  assign rf_read_data_2 = rf_mem[rf_read_index_2];
  always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_index] <= rf_write_data;

  // Architectural model
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [DEPTH-1:0] rd;
    logic             w;
  } exp_t;

  bit               m_busy [NREGS];
  logic [WIDTH-1:0] m_regs [NREGS];
  bit               m_ex_full;
  int unsigned      m_stalls;
  bit               last_issue;
  exp_t             expq[$];
  logic [DEPTH-1:0] inflight[$];
  int               n_cmp = 0;
  int               n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Evaluate one cycle against the model; called mid-cycle with inputs stable.
  task automatic model_eval();
    bit f1, f2, haz, rdy, iss;
    exp_t e;
`ifdef OPERAND_FORWARDING_EN
    f1 = wb_valid && (wb_index == dec_rs1) && (dec_rs1 != 0);
    f2 = wb_valid && (wb_index == dec_rs2) && (dec_rs2 != 0);
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    haz = (dec_rs1 != 0 && m_busy[dec_rs1] && !f1) || (dec_rs2 != 0 && m_busy[dec_rs2] && !f2);
    rdy = (!m_ex_full || ex_ready) && !haz;
    iss = dec_valid && rdy;
    check("dec_ready", 64'(dec_ready), 64'(rdy));
    check("ex_valid", 64'(ex_valid), 64'(m_ex_full));
    check("stall_count", 64'(stall_count), 64'(m_stalls));
    check("rf_write_enable", 64'(rf_write_enable), 64'(wb_valid && wb_index != 0));
    if (wb_valid && wb_index != 0)
      check("rf_write_port", {27'd0, rf_write_index, rf_write_data}, {27'd0, wb_index, wb_data});
    check("rf_read_port", {52'd0, rf_read_enable_1, rf_read_enable_2, rf_read_index_1, rf_read_index_2},
          {52'd0, dec_valid, dec_valid, dec_rs1, dec_rs2});
    if (iss) begin
      e.a  = (dec_rs1 == 0) ? '0 : (f1 ? wb_data : m_regs[dec_rs1]);
      e.b  = (dec_rs2 == 0) ? '0 : (f2 ? wb_data : m_regs[dec_rs2]);
      e.rd = dec_rd;
      e.w  = dec_rd_write;
      expq.push_back(e);
      if (dec_rd_write && dec_rd != 0) inflight.push_back(dec_rd);
    end
    if (wb_valid) m_busy[wb_index] = 1'b0;
    if (wb_valid && wb_index != 0) m_regs[wb_index] = wb_data;
    if (iss && dec_rd_write && dec_rd != 0) m_busy[dec_rd] = 1'b1;
    m_ex_full = iss ? 1'b1 : (ex_ready ? 1'b0 : m_ex_full);
    if (dec_valid && haz && m_stalls != 32'hFFFF) m_stalls++;
    last_issue = iss;
  endtask

  task automatic step(input logic dv, input logic [DEPTH-1:0] rs1, input logic [DEPTH-1:0] rs2,
                      input logic [DEPTH-1:0] rd, input logic rdw, input logic wbv,
                      input logic [DEPTH-1:0] wbi, input logic [WIDTH-1:0] wbd, input logic exr);
    @(posedge clk); #1;
    dec_valid = dv; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_rd_write = rdw;
    wb_valid = wbv; wb_index = wbi; wb_data = wbd; ex_ready = exr;
    @(negedge clk);
    model_eval();
  endtask

  task automatic rand_cycles(input int n);
    logic dv, rdw, wbv, exr;
    logic [DEPTH-1:0] rs1, rs2, rd, wbi;
    logic [WIDTH-1:0] wbd;
    for (int k = 0; k < n; k++) begin
      if (dec_valid && !last_issue) begin
        dv = 1'b1; rs1 = dec_rs1; rs2 = dec_rs2; rd = dec_rd; rdw = dec_rd_write;
      end else begin
        dv  = ($urandom_range(0, 9) < 8);
        rs1 = DEPTH'($urandom_range(0, 7));
        rs2 = DEPTH'($urandom_range(0, 7));
        rd  = DEPTH'($urandom_range(0, 7));
        rdw = ($urandom_range(0, 3) != 0);
      end
      wbv = ($urandom_range(0, 9) < 4);
      wbi = '0;
      if (wbv) begin
        if (inflight.size() > 0 && $urandom_range(0, 3) != 0) wbi = inflight.pop_front();
        else wbi = DEPTH'($urandom_range(0, 7));
      end
      wbd = $urandom;
      exr = ($urandom_range(0, 9) < 7);
      step(dv, rs1, rs2, rd, rdw, wbv, wbi, wbd, exr);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("queue_drained", 64'(expq.size()), 64'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    m_ex_full  = 1'b0;
    m_stalls   = 0;
    last_issue = 1'b1;
    expq.delete();
    inflight.delete();
  endtask

  // Monitor: pops the expected bundle whenever execute accepts one, and
  // checks that a stalled bundle does not change.
  bit   held = 1'b0;
  exp_t held_v;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held)
        check("ex_hold_stable", {ex_rs1_data, ex_rs2_data},
              {held_v.a, held_v.b});
      if (ex_valid && ex_ready) begin
        if (expq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ex_transfer: got unexpected bundle rd=%0d, expected none", ex_rd);
        end else begin
          e = expq.pop_front();
          check("ex_rs1_data", 64'(ex_rs1_data), 64'(e.a));
          check("ex_rs2_data", 64'(ex_rs2_data), 64'(e.b));
          check("ex_rd", {58'd0, ex_rd, ex_rd_write}, {58'd0, e.rd, e.w});
        end
      end
      held = ex_valid && !ex_ready;
      held_v.a = ex_rs1_data; held_v.b = ex_rs2_data; held_v.rd = ex_rd; held_v.w = ex_rd_write;
    end
  end

  initial begin
    reset = 1'b1;
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_write = 0;
    wb_valid = 0; wb_index = 0; wb_data = 0; ex_ready = 1;
    for (int i = 0; i < NREGS; i++) begin
      rf_mem[i] = (i == 0) ? 32'hFFFF_FFFF : $urandom;
      m_regs[i] = rf_mem[i];
    end
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_outputs", {ex_valid, ex_rd_write, ex_rd, stall_count, rf_read_enable_1, rf_write_enable},
          '0);
    check("reset_ex_data", {ex_rs1_data, ex_rs2_data}, 64'd0);
    check("reset_dec_ready", 64'(dec_ready), 64'd1);
    reset = 1'b0;

    // r0 sources read as zero despite the register file returning all ones;
    // writeback to r0 must not reach the register file.
    step(1, 0, 0, 0, 0, 1, 0, 32'h1234_5678, 1);
    // RAW hazard on r3 with no writeback: stalls and counts each cycle.
    step(1, 0, 0, 3, 1, 0, 0, 0, 1);
    repeat (3) step(1, 3, 0, 1, 0, 0, 0, 0, 1);
    // Writeback of r3 while r3 is requested.
    step(1, 3, 0, 1, 0, 1, 3, 32'hDEAD_BEEF, 1);
    step(1, 3, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Set of r5 coinciding with a writeback to r5: busy must persist.
    step(1, 0, 0, 5, 1, 1, 5, 32'h5555_0000, 1);
    repeat (2) step(1, 5, 0, 0, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 1, 5, 32'hA5A5_5A5A, 1);
    step(1, 0, 5, 0, 0, 0, 0, 0, 1);
    // Backpressure: ex full and not ready blocks decode but is not counted.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (4) step(1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0, 1);
    drain();

    rand_cycles(3000);
    drain();

    // Asynchronous reset with an occupied output register and a busy entry.
    step(1, 0, 0, 6, 1, 0, 0, 0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {ex_valid, ex_rd_write, ex_rd, stall_count}, '0);
    check("async_reset_ex_data", {ex_rs1_data, ex_rs2_data}, 64'd0);
    dec_valid = 1'b1; dec_rs1 = 6; dec_rs2 = 0; ex_ready = 1'b0; wb_valid = 1'b0;
    #1;
    check("async_reset_busy_cleared", 64'(dec_ready), 64'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    dec_valid = 1'b0;

    rand_cycles(800);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
